count_sequencer: RTL and testbench
==================================

Name: count_sequencer

Overview:
Controller that sequences a WIDTH-bit half-adder ripple counter as a programmable interval timer.
- A requester issues start with a terminal count (tc) and a mode: one-shot or periodic.
- The block runs the counter from 0 to tc, pulses done, then idles (one-shot) or reloads (periodic).
- Supports pause, graceful stop and immediate abort. Sits between control logic and the counter datapath.

Parameters:
WIDTH, 4, counter, tc and done_cnt width (>=2)
PRESCALE, 4, count-rate divisor when COUNT_SEQ_PRESCALE_EN is defined (>=2); ignored otherwise

Ports:
clk  input  1  clock; all logic on posedge
resn  input  1  reset, synchronous, active-low
start  input  1  request a run; sampled only in IDLE
tc  input  WIDTH  terminal count; captured on accepted start
periodic  input  1  mode select; captured on accepted start (1 = periodic)
pause  input  1  freeze the counter while high (RUN only)
stop  input  1  graceful stop: finish current period, then IDLE
abort  input  1  immediate stop, no done
busy  output  1  high while in RUN
done  output  1  one-cycle pulse at end of each period
cnt  output  WIDTH  current counter value
done_cnt  output  WIDTH  number of done pulses since last accepted start; wraps

Behaviour:
- Reset (resn=0 at posedge): state IDLE; cnt, done_cnt, tc_q, periodic_q, stop_q = 0; busy=0; done=0. Reset mid-run discards the run and emits no done.
- States: IDLE and RUN. busy = (state==RUN), registered.
- IDLE, start=1 at edge E0: tc_q<=tc, periodic_q<=periodic, stop_q<=0, cnt<=0, done_cnt<=0, state<=RUN. start=0: hold all values; cnt keeps its last value.
- RUN, per edge, priority abort > pause > count:
  - abort: state<=IDLE, cnt<=0, no done, done_cnt unchanged.
  - pause (no abort): cnt, state and done_cnt hold; done=0.
  - count, cnt!=tc_q: cnt<=cnt+1.
  - count, cnt==tc_q: cnt<=0, done<=1, done_cnt<=done_cnt+1 (mod 2^WIDTH). If periodic_q=0 or stop_q=1, state<=IDLE; otherwise remain in RUN.
- done is high for exactly one cycle per period. It is otherwise 0.
- Latency: done is visible in the cycle after edge E(tc_q+1). Period = tc_q+1 unpaused cycles.
- tc=0: done on every unpaused cycle in periodic mode; a single done one cycle after start in one-shot mode.
- tc = 2^WIDTH-1: full range; cnt reaches all-ones, then returns to 0 with done. No overflow beyond tc_q.
- stop in RUN sets stop_q (sticky until the next start). It does not alter cnt.
- stop in the same edge as the terminal count takes effect immediately: that done is the last one.
- In IDLE, stop, abort and pause are ignored.
- start while in RUN is ignored: no retrigger, and tc/periodic are not recaptured.
- start and abort on the same edge in IDLE: start is accepted.
- Changes to tc or periodic after acceptance have no effect until the next start.

Optional Feature:
COUNT_SEQ_PRESCALE_EN
- Defined: an internal prescaler counting 0..PRESCALE-1 gates the counter advance, so cnt moves only when the prescaler wraps.
  - Prescaler is cleared on accepted start, abort and reset; it freezes on pause.
  - Period becomes (tc_q+1)*PRESCALE cycles; done still lasts one cycle.
- Not defined: cnt advances every unpaused RUN cycle and PRESCALE is unused.

Decomposition:
- Package count_seq_pkg: state enum typedef {IDLE, RUN}; default WIDTH constant; PRESCALE default constant.
- Sub-module counter_core: WIDTH-bit half-adder ripple incrementer with enable and synchronous clear, flops on clk/resn.
  - count_sequencer drives its en and clr and compares its output to tc_q.

Test Plan:
- Reset held 3 cycles, then released, no start -> cnt=0, busy=0, done=0, done_cnt=0 throughout.
- start, tc=5, periodic=0 -> busy=1 the cycle after start; cnt 0,1,2,3,4,5; done pulses once 6 cycles after start; back to IDLE with cnt=0, done_cnt=1.
- start, tc=2, periodic=1, run 9 cycles, then stop -> done every 3 cycles; the current period completes; exactly one more done; IDLE.
- tc=7 one-shot, pause for 4 cycles at cnt=3 -> cnt holds 3; done arrives 4 cycles later than unpaused (12 cycles after start).
- One-shot tc=7, abort at cnt=4 -> next cycle IDLE, cnt=0, no done. Then start with abort on the same edge in IDLE -> run accepted.
- Periodic tc=0 for 20 cycles, then resn=0 mid-run -> done every cycle; done_cnt wraps 15->0. After reset: all outputs 0, state IDLE. With COUNT_SEQ_PRESCALE_EN, PRESCALE=4, tc=1 one-shot -> done 8 cycles after start.

Source files
------------

// File: rtl/count_seq_pkg.sv
// count_seq_pkg: shared types and defaults for the count_sequencer slice.
//   state_t      - controller state encoding (IDLE, RUN)
//   DEF_WIDTH    - default counter / terminal-count width
//   DEF_PRESCALE - default count-rate divisor (used only with COUNT_SEQ_PRESCALE_EN)
package count_seq_pkg;

    localparam int unsigned DEF_WIDTH    = 4;
    localparam int unsigned DEF_PRESCALE = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/count_sequencer_core.sv
// counter_core: WIDTH-bit half-adder ripple incrementer with enable and
// synchronous clear. Clear has priority over enable.
//   clk  - clock, posedge
//   resn - synchronous active-low reset (q -> 0)
//   en   - advance q by one
//   clr  - load q with zero
//   q    - counter value
module counter_core
    import count_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             resn,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum;

    // Chain of half adders: the enable is the carry-in of bit 0.
    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = en;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            sum[i]     = q[i] ^ carry[i];
            carry[i+1] = q[i] & carry[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!resn)
            q <= '0;
        else if (clr)
            q <= '0;
        else
            q <= sum;
    end

endmodule

// File: rtl/count_sequencer.sv
// count_sequencer: programmable interval timer controller driving counter_core.
// Counts 0..tc_q, pulses done, then idles (one-shot) or reloads (periodic).
// Optional macro COUNT_SEQ_PRESCALE_EN: counter advances once every PRESCALE
// unpaused RUN cycles.
//   clk      - clock, posedge
//   resn     - synchronous active-low reset
//   start    - request a run (accepted in IDLE only)
//   tc       - terminal count, captured on accepted start
//   periodic - mode, captured on accepted start (1 = periodic)
//   pause    - freeze while high (RUN only)
//   stop     - finish current period, then IDLE
//   abort    - immediate return to IDLE, no done
//   busy     - high while in RUN
//   done     - one-cycle pulse at end of each period
//   cnt      - current counter value
//   done_cnt - done pulses since last accepted start (wraps)
module count_sequencer
    import count_seq_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned PRESCALE = DEF_PRESCALE
) (
    input  logic             clk,
    input  logic             resn,
    input  logic             start,
    input  logic [WIDTH-1:0] tc,
    input  logic             periodic,
    input  logic             pause,
    input  logic             stop,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] cnt,
    output logic [WIDTH-1:0] done_cnt
);

    if (WIDTH < 2 || PRESCALE < 2) begin : g_param_check
        $error("count_sequencer: WIDTH and PRESCALE must be >= 2");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] tc_q, tc_d;
    logic             periodic_q, periodic_d;
    logic             stop_q, stop_d;
    logic             done_d;
    logic [WIDTH-1:0] done_cnt_d;
    logic             cnt_en, cnt_clr;
    logic             tick;

`ifdef COUNT_SEQ_PRESCALE_EN
    localparam int unsigned PW = $clog2(PRESCALE);
    logic [PW-1:0] pre_q, pre_d;
    logic          pre_adv, pre_clr;

    assign tick = (pre_q == PW'(PRESCALE - 1));

    always_comb begin
        pre_d = pre_q;
        if (pre_clr)
            pre_d = '0;
        else if (pre_adv)
            pre_d = tick ? '0 : pre_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!resn)
            pre_q <= '0;
        else
            pre_q <= pre_d;
    end
`else
    assign tick = 1'b1;
`endif

    counter_core #(.WIDTH(WIDTH)) u_core (
        .clk  (clk),
        .resn (resn),
        .en   (cnt_en),
        .clr  (cnt_clr),
        .q    (cnt)
    );

    always_comb begin
        state_d    = state_q;
        tc_d       = tc_q;
        periodic_d = periodic_q;
        stop_d     = stop_q;
        done_d     = 1'b0;
        done_cnt_d = done_cnt;
        cnt_en     = 1'b0;
        cnt_clr    = 1'b0;
`ifdef COUNT_SEQ_PRESCALE_EN
        pre_adv    = 1'b0;
        pre_clr    = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    tc_d       = tc;
                    periodic_d = periodic;
                    stop_d     = 1'b0;
                    done_cnt_d = '0;
                    cnt_clr    = 1'b1;
                    state_d    = RUN;
`ifdef COUNT_SEQ_PRESCALE_EN
                    pre_clr    = 1'b1;
`endif
                end
            end
            RUN: begin
                if (abort) begin
                    cnt_clr = 1'b1;
                    state_d = IDLE;
`ifdef COUNT_SEQ_PRESCALE_EN
                    pre_clr = 1'b1;
`endif
                end else begin
                    if (stop)
                        stop_d = 1'b1;
                    if (!pause) begin
`ifdef COUNT_SEQ_PRESCALE_EN
                        pre_adv = 1'b1;
`endif
                        if (tick) begin
                            if (cnt == tc_q) begin
                                cnt_clr    = 1'b1;
                                done_d     = 1'b1;
                                done_cnt_d = done_cnt + 1'b1;
                                // Raw stop is included so a stop on the
                                // terminal edge makes this done the last one.
                                if (!periodic_q || stop_q || stop)
                                    state_d = IDLE;
                            end else begin
                                cnt_en = 1'b1;
                            end
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resn) begin
            state_q    <= IDLE;
            tc_q       <= '0;
            periodic_q <= 1'b0;
            stop_q     <= 1'b0;
            done       <= 1'b0;
            done_cnt   <= '0;
        end else begin
            state_q    <= state_d;
            tc_q       <= tc_d;
            periodic_q <= periodic_d;
            stop_q     <= stop_d;
            done       <= done_d;
            done_cnt   <= done_cnt_d;
        end
    end

    assign busy = (state_q == RUN);

endmodule

// File: tb/tb_count_sequencer.sv
// tb_count_sequencer: directed self-checking bench for count_sequencer.
module tb_count_sequencer;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         resn, start, periodic, pause, stop, abort;
    logic [W-1:0] tc;
    logic         busy, done;
    logic [W-1:0] cnt, done_cnt;

    int unsigned vectors = 0;
    int unsigned errors  = 0;

    always #5 clk = ~clk;

    count_sequencer #(.WIDTH(W), .PRESCALE(4)) dut (
        .clk      (clk),
        .resn     (resn),
        .start    (start),
        .tc       (tc),
        .periodic (periodic),
        .pause    (pause),
        .stop     (stop),
        .abort    (abort),
        .busy     (busy),
        .done     (done),
        .cnt      (cnt),
        .done_cnt (done_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [W-1:0] e_cnt, input logic e_busy,
                           input logic e_done, input logic [W-1:0] e_dcnt);
        chk({tag, ".cnt"},      32'(cnt),      32'(e_cnt));
        chk({tag, ".busy"},     32'(busy),     32'(e_busy));
        chk({tag, ".done"},     32'(done),     32'(e_done));
        chk({tag, ".done_cnt"}, 32'(done_cnt), 32'(e_dcnt));
    endtask

    initial begin
        resn = 1'b0; start = 1'b0; periodic = 1'b0; pause = 1'b0;
        stop = 1'b0; abort = 1'b0; tc = '0;

        // Reset held 3 cycles, then idle with no start
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all("reset", 4'd0, 1'b0, 1'b0, 4'd0);
        end
        resn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all("idle", 4'd0, 1'b0, 1'b0, 4'd0);
        end

`ifndef COUNT_SEQ_PRESCALE_EN
        // One-shot tc=5; tc changed after acceptance must not matter
        start = 1'b1; tc = 4'd5; periodic = 1'b0;
        tick();
        start = 1'b0; tc = 4'd1; periodic = 1'b1;
        chk_all("os5.e0", 4'd0, 1'b1, 1'b0, 4'd0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk_all("os5.run", 4'(k), 1'b1, 1'b0, 4'd0);
        end
        tick();
        chk_all("os5.done", 4'd0, 1'b0, 1'b1, 4'd1);
        tick();
        chk_all("os5.idle", 4'd0, 1'b0, 1'b0, 4'd1);

        // Periodic tc=2, 9 cycles, then stop; start in RUN ignored
        start = 1'b1; tc = 4'd2; periodic = 1'b1;
        tick();
        start = 1'b0;
        chk_all("per2.e0", 4'd0, 1'b1, 1'b0, 4'd0);
        for (int k = 1; k <= 9; k++) begin
            tick();
            chk_all("per2.run", 4'(k % 3), 1'b1, (k % 3) == 0, 4'(k / 3));
        end
        stop = 1'b1; start = 1'b1; tc = 4'd0;
        tick();
        stop = 1'b0; start = 1'b0;
        chk_all("per2.stop", 4'd1, 1'b1, 1'b0, 4'd3);
        tick();
        chk_all("per2.last", 4'd2, 1'b1, 1'b0, 4'd3);
        tick();
        chk_all("per2.done", 4'd0, 1'b0, 1'b1, 4'd4);
        tick();
        chk_all("per2.idle", 4'd0, 1'b0, 1'b0, 4'd4);

        // One-shot tc=7 with a 4-cycle pause at cnt=3: done 12 cycles after start
        start = 1'b1; tc = 4'd7; periodic = 1'b0;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk_all("pause.pre", 4'(k), 1'b1, 1'b0, 4'd0);
        end
        pause = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_all("pause.hold", 4'd3, 1'b1, 1'b0, 4'd0);
        end
        pause = 1'b0;
        for (int k = 4; k <= 7; k++) begin
            tick();
            chk_all("pause.post", 4'(k), 1'b1, 1'b0, 4'd0);
        end
        tick();
        chk_all("pause.done", 4'd0, 1'b0, 1'b1, 4'd1);

        // One-shot tc=7, abort at cnt=4; then start+abort together in IDLE
        start = 1'b1; tc = 4'd7; periodic = 1'b0;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 4; k++) tick();
        chk_all("abort.pre", 4'd4, 1'b1, 1'b0, 4'd0);
        abort = 1'b1;
        tick();
        chk_all("abort.idle", 4'd0, 1'b0, 1'b0, 4'd0);
        start = 1'b1; tc = 4'd3;
        tick();
        start = 1'b0; abort = 1'b0;
        chk_all("abort.restart", 4'd0, 1'b1, 1'b0, 4'd0);
        for (int k = 1; k <= 3; k++) tick();
        chk_all("abort.run3", 4'd3, 1'b1, 1'b0, 4'd0);
        tick();
        chk_all("abort.done", 4'd0, 1'b0, 1'b1, 4'd1);
        // Controls other than start are ignored in IDLE
        pause = 1'b1; stop = 1'b1; abort = 1'b1;
        tick();
        pause = 1'b0; stop = 1'b0; abort = 1'b0;
        chk_all("idle.ignore", 4'd0, 1'b0, 1'b0, 4'd1);

        // Periodic tc=0: done every cycle, done_cnt wraps; reset mid-run
        start = 1'b1; tc = 4'd0; periodic = 1'b1;
        tick();
        start = 1'b0;
        chk_all("tc0.e0", 4'd0, 1'b1, 1'b0, 4'd0);
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk_all("tc0.run", 4'd0, 1'b1, 1'b1, 4'(k % 16));
        end
        resn = 1'b0;
        tick();
        chk_all("midreset", 4'd0, 1'b0, 1'b0, 4'd0);
        resn = 1'b1;
        tick();
        chk_all("post_reset", 4'd0, 1'b0, 1'b0, 4'd0);

        // Full range one-shot tc=15
        start = 1'b1; tc = 4'd15; periodic = 1'b0;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 15; k++) tick();
        chk_all("full.top", 4'd15, 1'b1, 1'b0, 4'd0);
        tick();
        chk_all("full.done", 4'd0, 1'b0, 1'b1, 4'd1);
`else
        // Prescaled one-shot tc=1, PRESCALE=4: done 8 cycles after start
        start = 1'b1; tc = 4'd1; periodic = 1'b0;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk_all("pre.run", 4'(k / 4), 1'b1, 1'b0, 4'd0);
        end
        tick();
        chk_all("pre.done", 4'd0, 1'b0, 1'b1, 4'd1);
        tick();
        chk_all("pre.idle", 4'd0, 1'b0, 1'b0, 4'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
